// File: rtl/mem_bridge.sv
// mem_bridge: CPU load/store port onto a single-beat, byte-laned word memory.
// Optional BUSY watchdog is compiled in when MEM_BRIDGE_TIMEOUT_EN is defined.
module mem_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_byte,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_we;
  logic        r_byte;
  logic        w_misaligned;
  logic        w_timeout;
  logic [7:0]  w_lane;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_bridge: TIMEOUT must be within 2..255");
  end

  assign w_misaligned = !cpu_byte && (cpu_addr[1:0] != 2'b00);

`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic [7:0] r_count;

  // Held at zero outside BUSY so every transfer starts its budget from scratch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_count <= 8'd0;
    else if (r_state != BUSY)
      r_count <= 8'd0;
    else if (!mem_ack)
      r_count <= r_count + 8'd1;
  end

  assign w_timeout = (r_count == 8'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cpu_req) w_next = w_misaligned ? ERR : BUSY;
      BUSY:    if (mem_ack) w_next = DONE;
               else if (w_timeout) w_next = ERR;
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    bus_err   = 1'b0;
    cpu_stall = 1'b0;
    case (r_state)
      IDLE: cpu_stall = cpu_req;
      BUSY: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_be    = r_byte ? (4'b0001 << r_addr[1:0]) : 4'b1111;
        cpu_stall = 1'b1;
      end
      ERR:     bus_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_byte  <= 1'b0;
    end else if (r_state == IDLE && cpu_req) begin
      r_addr  <= cpu_addr;
      r_wdata <= cpu_wdata;
      r_we    <= cpu_we;
      r_byte  <= cpu_byte;
    end
  end

  always_comb begin
    w_lane = mem_rdata[7:0];
    case (r_addr[1:0])
      2'd1:    w_lane = mem_rdata[15:8];
      2'd2:    w_lane = mem_rdata[23:16];
      2'd3:    w_lane = mem_rdata[31:24];
      default: w_lane = mem_rdata[7:0];
    endcase
  end

  // Stores complete without touching the load result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_rdata <= 32'd0;
    else if (r_state == BUSY && mem_ack && !r_we)
      r_rdata <= r_byte ? {{24{w_lane[7]}}, w_lane} : mem_rdata;
  end

  assign cpu_rdata = r_rdata;
  assign mem_addr  = r_addr[31:2];
  assign mem_wdata = r_byte ? {4{r_wdata[7:0]}} : r_wdata;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed cases, randomized accesses
// against an arithmetic reference model, reset during a transfer, watchdog.
module tb_mem_bridge;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic        cpu_byte = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int          nAssert = 0;
  int          nFail = 0;
  logic [31:0] modelRdata = 32'd0;

  mem_bridge #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_byte(cpu_byte),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkBit({tag, "_mem_req"}, mem_req, 1'b0);
    checkBit({tag, "_mem_we"}, mem_we, 1'b0);
    checkWord({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
    checkWord({tag, "_rdata"}, cpu_rdata, modelRdata);
  endtask

  // One CPU access; ackDelay = BUSY cycles before the one carrying mem_ack.
  task automatic doAccess(input logic we, input logic byt, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int ackDelay, input logic reqInDone);
    int          lane;
    int          stallSeen;
    bit          mis;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic [7:0]  b;
    lane     = int'(addr % 4);
    mis      = !byt && lane != 0;
    expBe    = byt ? 4'(1 << lane) : 4'b1111;
    expWdata = byt ? {4{wdata[7:0]}} : wdata;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_byte = byt; cpu_addr = addr; cpu_wdata = wdata;
    #1;
    checkBit("stall_on_req", cpu_stall, 1'b1);
    checkBit("no_mem_req_in_idle", mem_req, 1'b0);
    stallSeen = int'(cpu_stall);
    @(negedge clk);
    cpu_req = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;
    cpu_we = 1'($urandom); cpu_byte = 1'($urandom);
    #1;
    if (mis) begin
      checkBit("err_pulse", bus_err, 1'b1);
      checkBit("err_no_stall", cpu_stall, 1'b0);
      checkIdleOutputs("err");
      mem_ack = 1'b1; mem_rdata = $urandom;
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      checkBit("err_one_cycle", bus_err, 1'b0);
      checkIdleOutputs("after_err");
      return;
    end
    for (int i = 0; i <= ackDelay; i++) begin
      checkBit("busy_mem_req", mem_req, 1'b1);
      checkWord("busy_mem_addr", {2'b00, mem_addr}, addr >> 2);
      checkBit("busy_mem_we", mem_we, we);
      checkWord("busy_mem_be", {28'd0, mem_be}, {28'd0, expBe});
      if (we) checkWord("busy_mem_wdata", mem_wdata, expWdata);
      checkBit("busy_no_err", bus_err, 1'b0);
      stallSeen += int'(cpu_stall);
      if (i == ackDelay) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end else begin
        mem_rdata = $urandom;
      end
      @(negedge clk);
      #1;
    end
    mem_ack = 1'b0; mem_rdata = $urandom;
    if (!we) begin
      b = rdata[8*lane +: 8];
      modelRdata = byt ? {{24{b[7]}}, b} : rdata;
    end
    checkBit("done_no_stall", cpu_stall, 1'b0);
    checkBit("done_no_err", bus_err, 1'b0);
    checkIdleOutputs("done");
    checkWord("stall_cycles", stallSeen, ackDelay + 2);
    if (reqInDone) begin
      cpu_req = 1'b1;
      @(negedge clk);
      cpu_req = 1'b0;
      #1;
      checkBit("done_req_ignored_stall", cpu_stall, 1'b0);
      checkIdleOutputs("done_req_ignored");
    end else begin
      @(negedge clk);
      #1;
      checkIdleOutputs("back_idle");
    end
  endtask

  task automatic idleAck();
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checkIdleOutputs("idle_ack_ignored");
  endtask

  initial begin
    logic        we;
    logic        byt;
    logic [31:0] addr;

    #1;
    checkWord("reset_rdata", cpu_rdata, 32'd0);
    checkBit("reset_bus_err", bus_err, 1'b0);
    checkBit("reset_stall", cpu_stall, 1'b0);
    checkIdleOutputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    doAccess(1'b0, 1'b0, 32'h0000_0010, 32'd0, 32'h1234_5678, 0, 1'b0);
    doAccess(1'b0, 1'b1, 32'h0000_0013, 32'd0, 32'h80FF_FFFF, 0, 1'b0);
    doAccess(1'b0, 1'b1, 32'h0000_0012, 32'd0, 32'h80FF_FFFF, 0, 1'b0);
    doAccess(1'b1, 1'b1, 32'h0000_0021, 32'h0000_00AB, 32'h5555_5555, 1, 1'b0);
    doAccess(1'b1, 1'b0, 32'h0000_0022, 32'hCAFE_F00D, 32'd0, 0, 1'b0);
    idleAck();
    doAccess(1'b0, 1'b0, 32'h0000_0104, 32'd0, 32'hA5A5_0F0F, TB_TIMEOUT - 1, 1'b1);

    for (int n = 0; n < 40; n++) begin
      we   = 1'($urandom);
      byt  = 1'($urandom);
      addr = $urandom;
      if (!byt && ($urandom % 4) != 0) addr[1:0] = 2'b00;
      doAccess(we, byt, addr, $urandom, $urandom,
               int'($urandom_range(0, TB_TIMEOUT - 1)), 1'($urandom));
    end

`ifdef MEM_BRIDGE_TIMEOUT_EN
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 32'h0000_0200;
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      checkBit("to_mem_req_held", mem_req, 1'b1);
      checkBit("to_no_err_yet", bus_err, 1'b0);
      @(negedge clk);
      #1;
    end
    checkBit("to_bus_err", bus_err, 1'b1);
    checkIdleOutputs("to_err");
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checkBit("to_err_one_cycle", bus_err, 1'b0);
    checkIdleOutputs("to_late_ack");
`else
    doAccess(1'b0, 1'b0, 32'h0000_0300, 32'd0, 32'h0BAD_F00D, 20, 1'b0);
`endif

    doAccess(1'b0, 1'b0, 32'h0000_0044, 32'd0, 32'h7654_3210, 0, 1'b0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b0;
    cpu_addr = 32'h0000_0040; cpu_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    checkBit("pre_reset_busy", mem_req, 1'b1);
    rst = 1'b0;
    #1;
    modelRdata = 32'd0;
    checkBit("rst_mid_stall", cpu_stall, 1'b0);
    checkBit("rst_mid_bus_err", bus_err, 1'b0);
    checkWord("rst_mid_mem_addr", {2'b00, mem_addr}, 32'd0);
    checkWord("rst_mid_mem_wdata", mem_wdata, 32'd0);
    checkIdleOutputs("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    doAccess(1'b0, 1'b1, 32'h0000_0051, 32'd0, 32'h0000_7F00, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum BUSY cycles awaiting mem_ack (range 2..255).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 cpu_req  input  1  CPU data-access request; cpu_we  input  1  1=store, 0=load.
REQ-005 cpu_addr  input  32  byte address; cpu_wdata  input  32  store data.
REQ-006 cpu_byte  input  1  byte access (lb/sb) when 1, word access when 0.
REQ-007 cpu_rdata  output  32  load result; cpu_stall  output  1  CPU SHALL hold PC/IR while 1.
REQ-008 bus_err  output  1  one-cycle pulse on a misaligned or timed-out access.
REQ-009 mem_req  output  1; mem_we  output  1; mem_addr  output  30 (word address); mem_be  output  4; mem_wdata  output  32.
REQ-010 mem_ack  input  1  transfer-complete strobe; mem_rdata  input  32  read word, valid when mem_ack=1.

Function
REQ-011 FSM states SHALL be IDLE, BUSY, DONE, ERR; the encoding is left to the implementation.
REQ-012 In IDLE, cpu_req=1 SHALL latch addr/wdata/we/byte; the next state SHALL be BUSY, or ERR if cpu_byte=0 and cpu_addr[1:0]!=0.
REQ-013 cpu_stall SHALL equal (IDLE && cpu_req) || BUSY, combinationally.
REQ-014 In BUSY: mem_req=1, mem_addr=latched addr[31:2], mem_we=latched we; these SHALL remain stable until mem_ack.
REQ-015 Word access: mem_be=4'b1111, mem_wdata=latched wdata.
REQ-016 Byte store: mem_be=4'b0001<<addr[1:0], mem_wdata={4{wdata[7:0]}}.
REQ-017 Byte load: mem_be=4'b0001<<addr[1:0].
REQ-018 BUSY with mem_ack=1 SHALL capture the load result into cpu_rdata and go to DONE.
REQ-019 Byte-load result: byte addr[1:0] of mem_rdata (lane 0=[7:0]), sign-extended to 32 bits.
REQ-020 A store SHALL leave cpu_rdata unchanged.
REQ-021 DONE and ERR SHALL last exactly one cycle, then go to IDLE; cpu_req in these states SHALL be ignored.
REQ-022 ERR SHALL assert bus_err=1 and SHALL issue no memory transfer.
REQ-023 Outside BUSY: mem_req=0, mem_we=0, mem_be=0; mem_ack outside BUSY SHALL be ignored.
REQ-024 Minimum latency: request accepted at edge N, ack during N+1 -> DONE at N+2; cpu_stall is low in DONE.

Reset
REQ-025 rst=0 SHALL force IDLE immediately, including mid-transfer (mem_req drops without waiting for a clock).
REQ-026 Under reset: cpu_rdata=0, bus_err=0, timeout count=0, all latched request fields=0.

Configuration
REQ-027 With MEM_BRIDGE_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entering BUSY and increment each BUSY cycle without ack.
REQ-028 With MEM_BRIDGE_TIMEOUT_EN, reaching count TIMEOUT-1 without mem_ack SHALL go to ERR; ack on that same cycle SHALL win and go to DONE.
REQ-029 Without MEM_BRIDGE_TIMEOUT_EN, BUSY SHALL wait indefinitely, no counter SHALL exist, and bus_err SHALL come only from misalignment.

Verification
REQ-030 Word load @0x10, mem_rdata=0x12345678, ack one cycle after mem_req -> mem_addr=0x4, be=1111, cpu_rdata=0x12345678, stall high 2 cycles.
REQ-031 lb @0x13, mem_rdata=0x80FFFFFF -> be=1000, cpu_rdata=0xFFFFFF80; lb @0x12 same data -> cpu_rdata=0xFFFFFFFF.
REQ-032 sb @0x21, wdata=0x000000AB -> mem_we=1, be=0010, mem_wdata=0xABABABAB, cpu_rdata unchanged.
REQ-033 Word store @0x22 -> ERR, bus_err pulse, mem_req never asserted.
REQ-034 TIMEOUT_EN, TIMEOUT=4, no ack -> mem_req high 4 cycles, then bus_err pulse, IDLE; a late ack is ignored.
REQ-035 rst low during BUSY -> mem_req=0 within the same cycle, IDLE, all outputs at reset values.
